// File: rtl/frogger_pkg.sv
// Shared frogger playfield definitions.
//   state_t : lane engine FSM states
//   dir_t   : lane motion direction
//   X_LEFT / X_RIGHT : playfield edges in pixels; BLOCKSIZE : tile size
package frogger_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_t;

  localparam int unsigned X_LEFT    = 96;
  localparam int unsigned X_RIGHT   = 544;
  localparam int unsigned BLOCKSIZE = 32;

endpackage

// File: rtl/lane_mover.sv
// One playfield lane: config registers, level-scaled divider, tick counter, slot positions
// and the signed step pulse.
//   clk, reset      : clock, synchronous active-high reset
//   load, run       : FSM is in LOAD / RUN this cycle
//   level           : game level used to scale the divider
//   dir, len, gap, cnt, div : lane configuration, sampled only during load
//   obj_x, obj_valid: per-slot left-edge x and active flag
//   step            : +1 / -1 for one cycle after each tick, aligned with the obj_x update
module lane_mover
  import frogger_pkg::*;
#(
  parameter int unsigned OBJS_PER_LANE = 3,
  parameter int unsigned X_W           = 10,
  parameter int unsigned DIV_W         = 24,
  parameter int unsigned X_LEFT        = frogger_pkg::X_LEFT,
  parameter int unsigned X_RIGHT       = frogger_pkg::X_RIGHT,
  parameter int unsigned MIN_DIV       = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load,
  input  logic                           run,
  input  logic [3:0]                     level,
  input  logic                           dir,
  input  logic [X_W-1:0]                 len,
  input  logic [X_W-1:0]                 gap,
  input  logic [1:0]                     cnt,
  input  logic [DIV_W-1:0]               div,
  output logic [OBJS_PER_LANE*X_W-1:0]   obj_x,
  output logic [OBJS_PER_LANE-1:0]       obj_valid,
  output logic [1:0]                     step
);

  localparam logic [X_W-1:0]   XL   = X_W'(X_LEFT);
  localparam logic [X_W-1:0]   XR   = X_W'(X_RIGHT);
  localparam logic [DIV_W-1:0] MINV = DIV_W'(MIN_DIV);

  dir_t                              dir_q;
  logic [X_W-1:0]                    len_q;
  logic [DIV_W-1:0]                  div_q;
  logic [DIV_W-1:0]                  eff_q;
  logic [DIV_W-1:0]                  count_q;
  logic [OBJS_PER_LANE-1:0][X_W-1:0] x_q;
  logic [OBJS_PER_LANE-1:0]          valid_q;
  logic [1:0]                        step_q;
  logic [1:0]                        n_active;
  logic                              tick;

  // The floor never raises a divider above its own base value, so a fast base lane keeps
  // its programmed speed at level 0. A zero divider behaves as one tick per cycle.
  function automatic logic [DIV_W-1:0] calc_eff(input logic [DIV_W-1:0] d,
                                                input logic [3:0]       lv);
    logic [DIV_W+3:0] red;
    logic [DIV_W-1:0] scaled;
    logic [DIV_W-1:0] floor_v;
    logic [DIV_W-1:0] e;
    red     = {4'b0000, (d >> 4)} * {{DIV_W{1'b0}}, lv};
    scaled  = d - red[DIV_W-1:0];
    floor_v = (d < MINV) ? d : MINV;
    e       = (scaled < floor_v) ? floor_v : scaled;
    if (e == '0) e = DIV_W'(1);
    return e;
  endfunction

  // Wrap is decided on the pre-move position.
  function automatic logic [X_W-1:0] move_x(input logic [X_W-1:0] x, input dir_t d,
                                            input logic [X_W-1:0] l);
    logic [X_W-1:0] lo;
    lo = XL - l;
    if (d == RIGHT) return (x >= XR) ? lo : x + 1'b1;
    else            return (x <= lo) ? XR : x - 1'b1;
  endfunction

  always_comb begin
    n_active = cnt;
    if (cnt == 2'd0) n_active = 2'd1;
    else if (32'(cnt) > OBJS_PER_LANE) n_active = 2'(OBJS_PER_LANE);
  end

  assign tick = run && (count_q == eff_q - 1'b1);

  // gap and cnt only shape the layout, so they are consumed into the slot state at load.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q   <= LEFT;
      len_q   <= '0;
      div_q   <= '0;
      eff_q   <= '0;
      count_q <= '0;
      x_q     <= {OBJS_PER_LANE{XR}};
      valid_q <= '0;
      step_q  <= 2'b00;
    end else if (load) begin
      dir_q   <= dir_t'(dir);
      len_q   <= len;
      div_q   <= div;
      eff_q   <= calc_eff(div, level);
      count_q <= '0;
      step_q  <= 2'b00;
      for (int unsigned k = 0; k < OBJS_PER_LANE; k++) begin
        if (k < 32'(n_active)) begin
          x_q[k]     <= XL + X_W'(k) * gap;
          valid_q[k] <= 1'b1;
        end else begin
          x_q[k]     <= XR;
          valid_q[k] <= 1'b0;
        end
      end
    end else if (run) begin
      if (tick) begin
        count_q <= '0;
        eff_q   <= calc_eff(div_q, level);
        step_q  <= (dir_q == RIGHT) ? 2'b01 : 2'b11;
        for (int unsigned k = 0; k < OBJS_PER_LANE; k++) begin
          if (valid_q[k]) x_q[k] <= move_x(x_q[k], dir_q, len_q);
        end
      end else begin
        count_q <= count_q + 1'b1;
        step_q  <= 2'b00;
      end
    end else begin
      step_q <= 2'b00;
    end
  end

  assign obj_x     = x_q;
  assign obj_valid = valid_q;
  assign step      = step_q;

endmodule

// File: rtl/lane_scroller.sv
// Frogger lane engine: start/pause FSM plus one lane_mover per lane.
//   clk, reset : clock, synchronous active-high reset
//   start      : pulse, (re)load lane config and begin motion
//   pause      : level, freeze all motion while high
//   level      : game level 0..15, scales lane speed
//   lane_*     : flattened per-lane config (dir, len, gap, cnt, div)
//   obj_x, obj_valid : flattened per-slot position and active flag
//   lane_step  : flattened signed 2-bit step per lane
//   running    : high in RUN
module lane_scroller
  import frogger_pkg::*;
#(
  parameter int unsigned NUM_LANES     = 6,
  parameter int unsigned OBJS_PER_LANE = 3,
  parameter int unsigned X_W           = 10,
  parameter int unsigned DIV_W         = 24,
  parameter int unsigned X_LEFT        = frogger_pkg::X_LEFT,
  parameter int unsigned X_RIGHT       = frogger_pkg::X_RIGHT,
  parameter int unsigned MIN_DIV       = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic                                   pause,
  input  logic [3:0]                             level,
  input  logic [NUM_LANES-1:0]                   lane_dir,
  input  logic [NUM_LANES*X_W-1:0]               lane_len,
  input  logic [NUM_LANES*X_W-1:0]               lane_gap,
  input  logic [NUM_LANES*2-1:0]                 lane_cnt,
  input  logic [NUM_LANES*DIV_W-1:0]             lane_div,
  output logic [NUM_LANES*OBJS_PER_LANE*X_W-1:0] obj_x,
  output logic [NUM_LANES*OBJS_PER_LANE-1:0]     obj_valid,
  output logic [NUM_LANES*2-1:0]                 lane_step,
  output logic                                   running
);

  state_t state_q;
  logic   running_q;

  // start wins over pause in every active state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) state_q <= LOAD;
        end
        LOAD: begin
          state_q   <= RUN;
          running_q <= 1'b1;
        end
        RUN: begin
          if (start) begin
            state_q   <= LOAD;
            running_q <= 1'b0;
          end else if (pause) begin
            state_q   <= PAUSE;
            running_q <= 1'b0;
          end
        end
        PAUSE: begin
          if (start) begin
            state_q <= LOAD;
          end else if (!pause) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign running = running_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_mover #(
      .OBJS_PER_LANE (OBJS_PER_LANE),
      .X_W           (X_W),
      .DIV_W         (DIV_W),
      .X_LEFT        (X_LEFT),
      .X_RIGHT       (X_RIGHT),
      .MIN_DIV       (MIN_DIV)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .load      (state_q == LOAD),
      .run       (state_q == RUN),
      .level     (level),
      .dir       (lane_dir[i]),
      .len       (lane_len[i*X_W +: X_W]),
      .gap       (lane_gap[i*X_W +: X_W]),
      .cnt       (lane_cnt[i*2 +: 2]),
      .div       (lane_div[i*DIV_W +: DIV_W]),
      .obj_x     (obj_x[i*OBJS_PER_LANE*X_W +: OBJS_PER_LANE*X_W]),
      .obj_valid (obj_valid[i*OBJS_PER_LANE +: OBJS_PER_LANE]),
      .step      (lane_step[i*2 +: 2])
    );
  end

endmodule

// File: tb/tb_lane_scroller.sv
module tb_lane_scroller;

  localparam int NL = 6;
  localparam int NO = 3;
  localparam int XW = 10;
  localparam int DW = 24;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               pause;
  logic [3:0]         level;
  logic [NL-1:0]      lane_dir;
  logic [NL*XW-1:0]   lane_len;
  logic [NL*XW-1:0]   lane_gap;
  logic [NL*2-1:0]    lane_cnt;
  logic [NL*DW-1:0]   lane_div;
  logic [NL*NO*XW-1:0] obj_x;
  logic [NL*NO-1:0]   obj_valid;
  logic [NL*2-1:0]    lane_step;
  logic               running;

  int tests = 0;
  int fails = 0;
  int n;
  int bad;

  lane_scroller dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pause     (pause),
    .level     (level),
    .lane_dir  (lane_dir),
    .lane_len  (lane_len),
    .lane_gap  (lane_gap),
    .lane_cnt  (lane_cnt),
    .lane_div  (lane_div),
    .obj_x     (obj_x),
    .obj_valid (obj_valid),
    .lane_step (lane_step),
    .running   (running)
  );

  always #5 clk = ~clk;

  function automatic logic [XW-1:0] xs(input int l, input int k);
    return obj_x[(l*NO+k)*XW +: XW];
  endfunction

  function automatic logic [1:0] st(input int l);
    return lane_step[l*2 +: 2];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input logic d, input int len, input int gap,
                          input int cnt, input int div);
    lane_dir[l]            = d;
    lane_len[l*XW +: XW]   = XW'(len);
    lane_gap[l*XW +: XW]   = XW'(gap);
    lane_cnt[l*2 +: 2]     = 2'(cnt);
    lane_div[l*DW +: DW]   = DW'(div);
  endtask

  // Edges until lane l shows a nonzero step, or -1 after max edges.
  task automatic wait_step(input int l, input int max, output int cycles);
    cycles = -1;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk);
      #1;
      if (lane_step[l*2 +: 2] != 2'b00) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int s = 0; s < NL*NO; s++) check({tag, "_x"}, obj_x[s*XW +: XW], 544);
    check({tag, "_valid"}, obj_valid, 0);
    check({tag, "_step"}, lane_step, 0);
    check({tag, "_running"}, running, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; level = 4'd0;
    lane_dir = '0; lane_len = '0; lane_gap = '0; lane_cnt = '0; lane_div = '0;
    tick(3);
    reset = 1'b0;
    tick(20);
    check_reset_state("idle");

    set_lane(0, 1'b0, 64, 150, 3, 4);
    set_lane(1, 1'b1, 96, 448, 2, 4);
    set_lane(2, 1'b0, 64, 960, 2, 4);
    set_lane(3, 1'b1, 32, 0, 1, 320);
    set_lane(4, 1'b0, 0, 0, 0, 20);
    set_lane(5, 1'b1, 32, 100, 3, 1000);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    check("load_running", running, 1);
    check("load_l0s0", xs(0, 0), 96);
    check("load_l0s1", xs(0, 1), 246);
    check("load_l0s2", xs(0, 2), 396);
    check("load_l1s1", xs(1, 1), 544);
    check("load_l2s1", xs(2, 1), 32);
    check("load_l2s2", xs(2, 2), 544);
    check("load_valid", obj_valid, 18'b111_001_001_011_011_111);

    tick(3);
    check("pre_tick_x", xs(0, 0), 96);
    check("pre_tick_step", st(0), 2'b00);
    tick(1);
    check("t1_l0s0", xs(0, 0), 95);
    check("t1_l0s1", xs(0, 1), 245);
    check("t1_l0s2", xs(0, 2), 395);
    check("t1_l0_step", st(0), 2'b11);
    check("t1_l1_step", st(1), 2'b01);
    check("t1_l1s0", xs(1, 0), 97);
    check("t1_rwrap", xs(1, 1), 0);
    check("t1_l2s0", xs(2, 0), 95);
    check("t1_lwrap", xs(2, 1), 544);
    check("t1_l3_step", st(3), 2'b00);
    tick(1);
    check("t1_step_one_cycle", st(0), 2'b00);
    tick(3);
    check("t2_l0s0", xs(0, 0), 94);
    check("t2_l0s2", xs(0, 2), 394);
    check("t2_l0_step", st(0), 2'b11);
    check("t2_l1s1", xs(1, 1), 1);
    check("t2_l2s1", xs(2, 1), 543);

    // Pause mid-period: counter sits at 3 of 0..3 for the whole pause.
    tick(2);
    pause = 1'b1;
    tick(1);
    check("pause_running", running, 0);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (xs(0, 0) != 10'd94 || lane_step != '0) bad++;
    end
    check("pause_frozen_cycles", bad, 0);
    pause = 1'b0;
    tick(1);
    check("resume_running", running, 1);
    check("resume_x_held", xs(0, 0), 94);
    tick(1);
    check("resume_tick_x", xs(0, 0), 93);
    check("resume_tick_step", st(0), 2'b11);

    // start during PAUSE reloads the layout.
    pause = 1'b1;
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    pause = 1'b0;
    tick(1);
    check("reload_l0s0", xs(0, 0), 96);
    check("reload_l0s1", xs(0, 1), 246);
    check("reload_l0s2", xs(0, 2), 396);
    check("reload_l1s1", xs(1, 1), 544);
    check("reload_running", running, 1);

    // Simultaneous start and pause: LOAD, then RUN, then PAUSE.
    start = 1'b1;
    pause = 1'b1;
    tick(1);
    check("sp_load", running, 0);
    start = 1'b0;
    tick(1);
    check("sp_run", running, 1);
    tick(1);
    check("sp_pause", running, 0);
    pause = 1'b0;
    tick(1);

    // Level 0 load gives lane3 eff=320; raising level mid-period only shortens the next one.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    tick(100);
    level = 4'd4;
    wait_step(3, 400, n);
    check("lvl_first_period_rest", n, 220);
    wait_step(3, 400, n);
    check("lvl4_period", n, 240);

    // Level 15: lane4 div=20 scales to 5, floored to 16.
    level = 4'd15;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    wait_step(4, 100, n);
    check("min_div_first", n, 16);
    wait_step(4, 100, n);
    check("min_div_period", n, 16);

    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (xs(2, 2) != 10'd544 || obj_valid[2*NO+2] != 1'b0) bad++;
    end
    check("invalid_slot_fixed", bad, 0);
    check("still_running", running, 1);

    reset = 1'b1;
    tick(1);
    check_reset_state("midrst");
    reset = 1'b0;
    tick(5);
    check("post_rst_idle", running, 0);
    check("post_rst_valid", obj_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
